// File: rtl/mist_frame_tracker.sv
// Frame tracker for the MiST sim harness: VS/HS edge detect, frame counter, dump window, end-of-sim flag.
// Define MIST_FRAME_CHECK_EN to compile in the per-frame line counter and the sticky frame_err check.
module mist_frame_tracker #(
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] STOP_FRAME  = 32'd0,
    parameter int          LW          = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          VGA_VS,
    input  logic          VGA_HS,
    output logic [31:0]   frame_cnt,
    output logic          frame_stb,
    output logic          dump_en,
    output logic          dump_start,
    output logic          sim_done,
    output logic [LW-1:0] lines_per_frame,
    output logic          frame_err
);

    // state | meaning
    // IDLE  | just out of reset, no frame seen yet
    // WAIT  | counting frames, dump window not yet open
    // DUMP  | inside the dump window, dump_en high
    // DONE  | stop frame reached, sim_done high until rst
    typedef enum logic [1:0] {IDLE, WAIT, DUMP, DONE} state_t;

    state_t      state;
    logic        vs_l;
    logic        vs_armed;
    logic        vs_fall;
    logic [31:0] frame_nxt;
    logic [32:0] start_diff;
    logic [32:0] stop_diff;
    logic        start_hit;
    logic        stop_hit;

    // A VS already low at reset release is not an edge: VS must be seen high first.
    assign vs_fall   = vs_armed & vs_l & ~VGA_VS;
    assign frame_nxt = frame_cnt + 32'd1;

    // Unsigned >= done via the borrow bit so a zero parameter does not fold to a constant compare.
    assign start_diff = {1'b0, frame_nxt} - {1'b0, START_FRAME};
    assign stop_diff  = {1'b0, frame_nxt} - {1'b0, STOP_FRAME};
    assign start_hit  = ~start_diff[32];
    assign stop_hit   = (STOP_FRAME != 32'd0) & ~stop_diff[32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_l       <= 1'b1;
            vs_armed   <= 1'b0;
            frame_cnt  <= 32'd0;
            frame_stb  <= 1'b0;
            dump_en    <= 1'b0;
            dump_start <= 1'b0;
            sim_done   <= 1'b0;
            state      <= IDLE;
        end else begin
            vs_l       <= VGA_VS;
            frame_stb  <= vs_fall;
            dump_start <= 1'b0;
            if (VGA_VS) begin
                vs_armed <= 1'b1;
            end
            if (vs_fall) begin
                frame_cnt <= frame_nxt;
                case (state)
                    IDLE, WAIT: begin
                        if (stop_hit) begin
                            state    <= DONE;
                            dump_en  <= 1'b0;
                            sim_done <= 1'b1;
                        end else if (start_hit) begin
                            state      <= DUMP;
                            dump_en    <= 1'b1;
                            dump_start <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    DUMP: begin
                        if (stop_hit) begin
                            state    <= DONE;
                            dump_en  <= 1'b0;
                            sim_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MIST_FRAME_CHECK_EN
    localparam logic [LW-1:0] LINE_MAX = '1;

    logic          hs_l;
    logic          hs_rise;
    logic [LW-1:0] line_cnt;

    assign hs_rise = ~hs_l & VGA_HS;

    // The first partial frame and first full frame have no valid reference, hence frame_cnt >= 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_l            <= 1'b1;
            line_cnt        <= '0;
            lines_per_frame <= '0;
            frame_err       <= 1'b0;
        end else begin
            hs_l <= VGA_HS;
            if (vs_fall) begin
                lines_per_frame <= line_cnt;
                line_cnt        <= hs_rise ? LW'(1) : '0;
                if ((frame_cnt >= 32'd2) && (line_cnt != lines_per_frame)) begin
                    frame_err <= 1'b1;
                end
            end else if (hs_rise && (line_cnt != LINE_MAX)) begin
                line_cnt <= line_cnt + LW'(1);
            end
        end
    end
`else
    logic hs_unused;

    assign hs_unused       = VGA_HS;
    assign lines_per_frame = '0;
    assign frame_err       = 1'b0;
`endif

endmodule
